// File: rtl/uart_word_rx.sv
// =============================================================================
// Module   : uart_word_rx
// Brief    : 8N1 UART receiver that packs four bytes (first byte in [7:0]) into
//            a 32-bit word with a valid/ready output and sticky error flags.
//            Define UART_WORD_RX_PARITY_EN for 8E1 frames and a parity_err port.
// Revision : 1.0
// =============================================================================
`default_nettype none

module uart_word_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    output logic [31:0] word_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [1:0]  byte_lane,
    output logic        frame_err,
    output logic        overrun_err,
`ifdef UART_WORD_RX_PARITY_EN
    output logic        parity_err,
`endif
    input  logic        err_clr
);

    localparam logic [15:0] HALF_BIT = 16'(CLKS_PER_BIT / 2);
    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_WORD_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t      state, next_state;
    logic        rxd_meta, rxd_s;
    logic [15:0] cnt, cnt_next;
    logic [2:0]  bit_idx, bit_next;
    logic [7:0]  shreg;
    logic [23:0] asm_word;
    logic        shift, stop_ok, stop_bad;
    logic        byte_accept, word_load, overrun_set;

    // Two-flop synchronizer; reset to the idle line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            state   <= next_state;
            cnt     <= cnt_next;
            bit_idx <= bit_next;
        end
    end

`ifdef UART_WORD_RX_PARITY_EN
    logic par_chk, par_set, par_bad;
`endif

    always_comb begin
        next_state = state;
        cnt_next   = cnt + 16'd1;
        bit_next   = bit_idx;
        shift      = 1'b0;
        stop_ok    = 1'b0;
        stop_bad   = 1'b0;
`ifdef UART_WORD_RX_PARITY_EN
        par_chk    = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                cnt_next = '0;
                bit_next = '0;
                if (!rxd_s) next_state = S_START;
            end
            S_START: begin
                if (cnt == HALF_BIT) begin
                    cnt_next   = '0;
                    next_state = rxd_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == LAST_CNT) begin
                    cnt_next = '0;
                    shift    = 1'b1;
                    bit_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_WORD_RX_PARITY_EN
                        next_state = S_PARITY;
`else
                        next_state = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_WORD_RX_PARITY_EN
            S_PARITY: begin
                if (cnt == LAST_CNT) begin
                    cnt_next   = '0;
                    par_chk    = 1'b1;
                    next_state = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt == LAST_CNT) begin
                    cnt_next = '0;
                    if (rxd_s) begin
                        stop_ok    = 1'b1;
                        next_state = S_IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        next_state = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                cnt_next = '0;
                if (rxd_s) next_state = S_IDLE;
            end
            default: begin
                cnt_next   = '0;
                next_state = S_IDLE;
            end
        endcase
    end

`ifdef UART_WORD_RX_PARITY_EN
    // Even parity: data bits plus parity bit must XOR to zero.
    assign par_set     = par_chk && (rxd_s != ^shreg);
    assign byte_accept = stop_ok && !par_bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (par_chk) par_bad <= par_set;
            parity_err <= par_set | (parity_err & ~err_clr);
        end
    end
`else
    assign byte_accept = stop_ok;
`endif

    assign word_load   = byte_accept && (byte_lane == 2'd3) && (!word_valid || word_ready);
    assign overrun_set = byte_accept && (byte_lane == 2'd3) && word_valid && !word_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg       <= '0;
            asm_word    <= '0;
            byte_lane   <= '0;
            word_data   <= '0;
            word_valid  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (shift) shreg <= {rxd_s, shreg[7:1]};

            if (byte_accept) begin
                case (byte_lane)
                    2'd0:    asm_word[7:0]   <= shreg;
                    2'd1:    asm_word[15:8]  <= shreg;
                    2'd2:    asm_word[23:16] <= shreg;
                    default: ;
                endcase
                byte_lane <= byte_lane + 2'd1;
            end

            // A new word may replace one that is transferring on this same edge.
            if (word_load) begin
                word_data  <= {shreg, asm_word};
                word_valid <= 1'b1;
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end

            frame_err   <= stop_bad | (frame_err & ~err_clr);
            overrun_err <= overrun_set | (overrun_err & ~err_clr);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_word_rx.sv
// =============================================================================
// Module   : tb_uart_word_rx
// Brief    : Directed-frame bench for uart_word_rx with a frame-level reference
//            model compared every quiet cycle, plus literal spot checks.
// Revision : 1.0
// =============================================================================
`default_nettype none

module tb_uart_word_rx;

    localparam int C = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rxd = 1'b1;
    logic [31:0] word_data;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic [1:0]  byte_lane;
    logic        frame_err;
    logic        overrun_err;
    logic        err_clr = 1'b0;
`ifdef UART_WORD_RX_PARITY_EN
    logic        parity_err;
`endif

    uart_word_rx #(.CLKS_PER_BIT(C)) dut (
        .clk         (clk),
        .rst         (rst),
        .rxd         (rxd),
        .word_data   (word_data),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .byte_lane   (byte_lane),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
`ifdef UART_WORD_RX_PARITY_EN
        .parity_err  (parity_err),
`endif
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;
    int xfer_cnt = 0;

    // Reference model: lane contents and output expectations at frame level.
    int          m_lane = 0;
    logic [7:0]  m_asm [3];
    logic [31:0] m_data = '0;
    bit          m_valid = 0, m_ferr = 0, m_oerr = 0, m_perr = 0;
    int          m_xfer = 0;

    always @(posedge clk) if (word_valid && word_ready) xfer_cnt <= xfer_cnt + 1;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            cmp("word_data", word_data, m_data);
            cmp("word_valid", 32'(word_valid), 32'(m_valid));
            cmp("byte_lane", 32'(byte_lane), 32'(m_lane));
            cmp("frame_err", 32'(frame_err), 32'(m_ferr));
            cmp("overrun_err", 32'(overrun_err), 32'(m_oerr));
            cmp("xfer_count", 32'(xfer_cnt), 32'(m_xfer));
`ifdef UART_WORD_RX_PARITY_EN
            cmp("parity_err", 32'(parity_err), 32'(m_perr));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic model_reset();
        m_lane = 0; m_data = '0; m_valid = 0;
        m_ferr = 0; m_oerr = 0; m_perr = 0;
    endtask

    task automatic model_frame(input logic [7:0] b, input bit stop_hi, input bit par_bit);
        bit perr;
        perr = 1'b0;
`ifdef UART_WORD_RX_PARITY_EN
        perr = (par_bit != ^b);
        if (perr) m_perr = 1;
`endif
        if (!stop_hi) m_ferr = 1;
        else if (!perr) begin
            if (m_lane < 3) begin
                m_asm[m_lane] = b;
                m_lane++;
            end else begin
                if (!m_valid || word_ready) begin
                    if (m_valid) m_xfer++;
                    m_data = {b, m_asm[2], m_asm[1], m_asm[0]};
                    if (word_ready) begin
                        m_xfer++;
                        m_valid = 0;
                    end else m_valid = 1;
                end else m_oerr = 1;
                m_lane = 0;
            end
        end
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (C) tick();
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_hi, input bit par_bit);
        check_en = 0;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_WORD_RX_PARITY_EN
        drive_bit(par_bit);
`endif
        drive_bit(stop_hi);
        rxd = 1'b1;
        repeat (6) tick();
        model_frame(b, stop_hi, par_bit);
        check_en = 1;
        repeat (4) tick();
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b1, ^b);
    endtask

    task automatic set_ready(input logic v);
        check_en = 0;
        word_ready = v;
        tick();
        if (v && m_valid) begin
            m_valid = 0;
            m_xfer++;
        end
        check_en = 1;
        tick();
    endtask

    task automatic pulse_clr();
        check_en = 0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_ferr = 0; m_oerr = 0; m_perr = 0;
        check_en = 1;
        tick();
    endtask

    initial begin
        model_reset();
        check_en = 1;
        repeat (3) tick();
        rst = 1'b1;
        repeat (5) tick();
        cmp("reset_word_data", word_data, 32'h0);
        cmp("reset_byte_lane", 32'(byte_lane), 32'd0);

        // Four bytes with ready high: one pulse, little-endian word.
        set_ready(1'b1);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        cmp("word_1234", word_data, 32'h12345678);
        cmp("lane_wrap", 32'(byte_lane), 32'd0);
        cmp("one_xfer", 32'(xfer_cnt), 32'd1);
        cmp("no_ferr", 32'(frame_err), 32'd0);

        // Overrun: second word dropped while first is held.
        set_ready(1'b0);
        for (int i = 1; i <= 8; i++) send(8'(i));
        cmp("held_word", word_data, 32'h04030201);
        cmp("held_valid", 32'(word_valid), 32'd1);
        cmp("overrun_set", 32'(overrun_err), 32'd1);
        set_ready(1'b1);
        cmp("drained_valid", 32'(word_valid), 32'd0);
        cmp("two_xfers", 32'(xfer_cnt), 32'd2);
        pulse_clr();
        cmp("overrun_clr", 32'(overrun_err), 32'd0);

        // Framing error then a good byte.
        send_frame(8'h55, 1'b0, ^8'h55);
        send(8'hAA);
        cmp("frame_err_set", 32'(frame_err), 32'd1);
        cmp("lane_after_ferr", 32'(byte_lane), 32'd1);
        pulse_clr();
        cmp("frame_err_clr", 32'(frame_err), 32'd0);
        send(8'h01); send(8'h02); send(8'h03);
        cmp("lane0_is_aa", word_data, 32'h030201AA);

        // Short glitch must be rejected.
        rxd = 1'b0;
        repeat (4) tick();
        rxd = 1'b1;
        repeat (40) tick();
        cmp("glitch_lane", 32'(byte_lane), 32'd0);

        // Reset in the middle of the third byte's data bits.
        set_ready(1'b0);
        send(8'h11); send(8'h22);
        check_en = 0;
        drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b0);
        rst = 1'b0;
        rxd = 1'b1;
        model_reset();
        check_en = 1;
        repeat (3) tick();
        rst = 1'b1;
        repeat (10) tick();
        cmp("post_reset_lane", 32'(byte_lane), 32'd0);
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        cmp("word_deadbeef", word_data, 32'hEFBEADDE);
        cmp("deadbeef_valid", 32'(word_valid), 32'd1);
        set_ready(1'b1);

`ifdef UART_WORD_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        cmp("parity_err_set", 32'(parity_err), 32'd1);
        cmp("parity_lane", 32'(byte_lane), 32'd0);
        pulse_clr();
`endif

        check_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
